// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory channel arbiter.
package idli_pkg;

   typedef enum logic {
      ARB_STATE_SETUP,
      ARB_STATE_DATA
   } arb_state_t;

   typedef enum logic {
      ARB_OWNER_FETCH,
      ARB_OWNER_MEM
   } arb_owner_t;

   // INIT, ADDR and DUMMY periods precede every data period.
   localparam int unsigned ARB_SETUP_PERIODS = 3;

endpackage

// File: rtl/idli_sqi_arb_m.sv
// SQI channel arbiter: sequences fetch streaming and LD/ST accesses on 4-cycle period boundaries.
// Define IDLI_ARB_B2B_EN to grant a waiting mem_req directly at mem done (no fetch word between).
module idli_sqi_arb_m
   import idli_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        i_arb_gck,
   input  logic        i_ctrl_rst_n,
   input  logic        i_arb_last_cycle,
   input  logic        i_arb_fetch_redirect,
   input  logic [15:0] i_arb_fetch_addr,
   output logic        o_arb_fetch_gnt,
   input  logic        i_arb_mem_req,
   input  logic        i_arb_mem_wr,
   input  logic [15:0] i_arb_mem_addr,
   output logic        o_arb_mem_gnt,
   output logic        o_arb_mem_done,
   output logic        o_arb_sqi_restart,
   output logic [15:0] o_arb_sqi_addr,
   output logic        o_arb_sqi_rd,
   output logic        o_arb_owner
);

   localparam logic [1:0] SETUP_LAST = 2'(ARB_SETUP_PERIODS - 1);

   arb_state_t  state_q, state_d;
   arb_owner_t  owner_q, owner_d;
   logic [1:0]  setup_q, setup_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] addr_q, addr_d;
   logic        rd_q, rd_d;
   logic [15:0] redir_addr;

   assign redir_addr = {i_arb_fetch_addr[15:1], 1'b0};

   always_comb begin
      state_d           = state_q;
      owner_d           = owner_q;
      setup_d           = setup_q;
      pc_d              = pc_q;
      addr_d            = addr_q;
      rd_d              = rd_q;
      o_arb_fetch_gnt   = 1'b0;
      o_arb_mem_gnt     = 1'b0;
      o_arb_mem_done    = 1'b0;
      o_arb_sqi_restart = 1'b0;

      if (i_arb_last_cycle) begin
         unique case (state_q)
            ARB_STATE_SETUP: begin
               if (owner_q == ARB_OWNER_FETCH && i_arb_fetch_redirect) begin
                  o_arb_sqi_restart = 1'b1;
                  addr_d            = redir_addr;
                  rd_d              = 1'b1;
                  pc_d              = redir_addr;
                  setup_d           = 2'd0;
               end else begin
                  // Mem setup cannot be aborted; only remember where fetch resumes.
                  if (i_arb_fetch_redirect) pc_d = redir_addr;
                  if (setup_q == SETUP_LAST) begin
                     state_d = ARB_STATE_DATA;
                     setup_d = 2'd0;
                  end else begin
                     setup_d = setup_q + 2'd1;
                  end
               end
            end
            ARB_STATE_DATA: begin
               if (owner_q == ARB_OWNER_FETCH) begin
                  o_arb_fetch_gnt = 1'b1;
                  pc_d = i_arb_fetch_redirect ? redir_addr : pc_q + 16'd2;
                  if (i_arb_mem_req) begin
                     o_arb_mem_gnt     = 1'b1;
                     o_arb_sqi_restart = 1'b1;
                     addr_d            = i_arb_mem_addr;
                     rd_d              = ~i_arb_mem_wr;
                     owner_d           = ARB_OWNER_MEM;
                     state_d           = ARB_STATE_SETUP;
                  end else if (i_arb_fetch_redirect) begin
                     o_arb_sqi_restart = 1'b1;
                     addr_d            = redir_addr;
                     rd_d              = 1'b1;
                     state_d           = ARB_STATE_SETUP;
                  end
               end else begin
                  o_arb_mem_done    = 1'b1;
                  o_arb_sqi_restart = 1'b1;
                  state_d           = ARB_STATE_SETUP;
                  owner_d           = ARB_OWNER_FETCH;
                  rd_d              = 1'b1;
                  addr_d            = i_arb_fetch_redirect ? redir_addr : pc_q;
                  if (i_arb_fetch_redirect) pc_d = redir_addr;
`ifdef IDLI_ARB_B2B_EN
                  if (i_arb_mem_req) begin
                     o_arb_mem_gnt = 1'b1;
                     addr_d        = i_arb_mem_addr;
                     rd_d          = ~i_arb_mem_wr;
                     owner_d       = ARB_OWNER_MEM;
                  end
`endif
               end
            end
            default: state_d = ARB_STATE_SETUP;
         endcase
      end
   end

   // addr_d/rd_d equal the held values unless a restart is issued this cycle.
   assign o_arb_sqi_addr = addr_d;
   assign o_arb_sqi_rd   = rd_d;
   assign o_arb_owner    = (owner_q == ARB_OWNER_MEM);

   always_ff @(posedge i_arb_gck or negedge i_ctrl_rst_n) begin
      if (!i_ctrl_rst_n) begin
         state_q <= ARB_STATE_SETUP;
         owner_q <= ARB_OWNER_FETCH;
         setup_q <= 2'd0;
         addr_q  <= RESET_PC;
         rd_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         setup_q <= setup_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge i_arb_gck or negedge i_ctrl_rst_n) begin
      if (!i_ctrl_rst_n) pc_q <= RESET_PC;
      else               pc_q <= pc_d;
   end

endmodule
